// File: rtl/multitap_delay_line.sv
// Multi-channel audio delay line: each accepted sample is stored in a circular
// RAM and CHANNELS delayed taps are read back, one per cycle, with own delays.
module multitap_delay_line #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 8,
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_sample,
  input  logic              delay_we,
  input  logic [CH_W-1:0]   delay_ch,
  input  logic [ADDR_W-1:0] delay_val,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [WIDTH-1:0]  out_sample,
  output logic              out_last
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FILL_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]     fill_q, fill_d;
  logic [ADDR_W-1:0]   delay_q [CHANNELS];
  logic [ADDR_W-1:0]   delay_d [CHANNELS];
  logic [ADDR_W-1:0]   shadow_q [CHANNELS];
  logic [ADDR_W-1:0]   shadow_d [CHANNELS];
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [CH_W-1:0]     out_ch_q, out_ch_d;
  logic [WIDTH-1:0]    out_sample_q, out_sample_d;
  logic                out_last_q, out_last_d;

  logic [WIDTH-1:0]    ram_q [DEPTH];

  logic                accept_s;
  logic [ADDR_W-1:0]   sel_delay_s;
  logic [ADDR_W-1:0]   raddr_s;
  logic                mask_s;

  assign accept_s = in_valid & in_ready_q & (state_q == IDLE);

  // Tap address for the channel being read; taps older than fill are masked.
  always_comb begin
    sel_delay_s = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cnt_q == CH_W'(k)) begin
        sel_delay_s = shadow_q[k];
      end else begin
        sel_delay_s = sel_delay_s;
      end
    end
    raddr_s = wptr_q - sel_delay_s;
    mask_s  = ({1'b0, sel_delay_s} >= fill_q);
  end

  // Next-state, delay register and output computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wptr_d   = wptr_q;
    fill_d   = fill_q;
    shadow_d = shadow_q;
    for (int k = 0; k < CHANNELS; k++) begin
      if (delay_we && (delay_ch == CH_W'(k))) begin
        delay_d[k] = delay_val;
      end else begin
        delay_d[k] = delay_q[k];
      end
    end

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d  = READ;
          cnt_d    = '0;
          shadow_d = delay_q;
          fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + (ADDR_W + 1)'(1);
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (cnt_q == LAST_CH) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CH_W'(1);
        end
      end
      DONE: begin
        // Write pointer advances only once the frame's reads are all issued.
        state_d = IDLE;
        wptr_d  = wptr_q + ADDR_W'(1);
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_q == READ);
    out_last_d  = (state_q == READ) && (cnt_q == LAST_CH);
    if (state_q == READ) begin
      out_ch_d     = cnt_q;
      out_sample_d = mask_s ? '0 : ram_q[raddr_s];
    end else begin
      out_ch_d     = '0;
      out_sample_d = '0;
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wptr_q       <= '0;
      fill_q       <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        delay_q[k]  <= '0;
        shadow_q[k] <= '0;
      end
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_sample_q <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wptr_q       <= wptr_d;
      fill_q       <= fill_d;
      delay_q      <= delay_d;
      shadow_q     <= shadow_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      out_sample_q <= out_sample_d;
      out_last_q   <= out_last_d;
    end
  end

  // Sample storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      ram_q[wptr_q] <= in_sample;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;
  assign out_sample = out_sample_q;
  assign out_last   = out_last_q;

endmodule
